div_counter_gen: RTL and testbench

Parametrised prescaled up/down counter for display and timebase use. It counts by a programmable modulus and supports a synchronous load. Unlike the earlier divider-plus-counter pair, it runs entirely on the board clock: an internal prescaler produces a clock-enable strobe, so no derived clock is generated. It sits between the board clock input and downstream display or sequencing logic, and provides tick and terminal-count pulses for cascading.

---
 rtl/div_counter_gen.sv | 82 ++++++++
 tb/tb_div_counter_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_counter_gen.sv
// rtl/div_counter_gen.sv - prescaled up/down modulus counter with tick/tc pulses
// Define DIV_COUNTER_GEN_SAT_EN to saturate at the ends instead of wrapping.
module div_counter_gen #(
    parameter int W   = 4,
    parameter int MOD = 16,
    parameter int DIV = 50000000
) (
    input  logic         clki,
    input  logic         rs,
    input  logic         en,
    input  logic         up,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic         tick,
    output logic         tc
);

    localparam int              PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]   PLAST = PW'(DIV - 1);
    localparam logic [W-1:0]    QMAX  = W'(MOD - 1);
    // One extra bit so MOD == 2**W still compares correctly against d
    localparam logic [W:0]      MODX  = (W + 1)'(MOD);

    logic [PW-1:0] pcnt;
    logic          stb;
    logic          at_top;
    logic          at_bot;
    logic          wrap;
    logic [W-1:0]  q_step;
    logic [W-1:0]  q_load;

    assign stb    = en && (pcnt == PLAST);
    assign at_top = (q == QMAX);
    assign at_bot = (q == '0);
    assign wrap   = up ? at_top : at_bot;
    assign q_load = ({1'b0, d} < MODX) ? d : QMAX;

    always_comb begin
        q_step = q;
        if (up) begin
            q_step = at_top ? '0 : q + 1'b1;
        end else begin
            q_step = at_bot ? QMAX : q - 1'b1;
        end
    end

    always_ff @(posedge clki) begin
        if (rs) begin
            q    <= '0;
            pcnt <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else if (ld) begin
            q    <= q_load;
            pcnt <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
            if (stb) begin
                pcnt <= '0;
`ifdef DIV_COUNTER_GEN_SAT_EN
                if (wrap) begin
                    tc <= 1'b1;
                end else begin
                    q    <= q_step;
                    tick <= 1'b1;
                end
`else
                q    <= q_step;
                tick <= 1'b1;
                tc   <= wrap;
`endif
            end else if (en) begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_div_counter_gen.sv
// tb/tb_div_counter_gen.sv - scoreboard bench for div_counter_gen (DIV=3 and DIV=1 instances)
module tb_div_counter_gen;

`ifdef DIV_COUNTER_GEN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        int         cyc;
        logic [3:0] q;
        logic       tick;
        logic       tc;
        bit         chk;
    } exp_t;

    logic       clki = 1'b0;
    logic       rs = 1'b1, en = 1'b1, up = 1'b1, ld = 1'b0;
    logic [3:0] d = 4'd0;
    logic [3:0] q;
    logic       tick, tc;

    logic       rs1 = 1'b1, en1 = 1'b1, up1 = 1'b1, ld1 = 1'b0;
    logic [3:0] d1 = 4'd0;
    logic [3:0] q1;
    logic       tick1, tc1;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t sb1[$];

    div_counter_gen #(.W(4), .MOD(10), .DIV(3)) dut (
        .clki(clki), .rs(rs), .en(en), .up(up), .ld(ld), .d(d),
        .q(q), .tick(tick), .tc(tc)
    );

    div_counter_gen #(.W(4), .MOD(10), .DIV(1)) dut1 (
        .clki(clki), .rs(rs1), .en(en1), .up(up1), .ld(ld1), .d(d1),
        .q(q1), .tick(tick1), .tc(tc1)
    );

    always #5 clki = ~clki;

    always @(posedge clki) cyc <= cyc + 1;

    function automatic exp_t mk(int c, logic [3:0] eq, logic et, logic etc, bit chk);
        exp_t e;
        e.cyc = c; e.q = eq; e.tick = et; e.tc = etc; e.chk = chk;
        return e;
    endfunction

    task automatic compare(input string nm, input exp_t e, input logic [3:0] aq,
                           input logic at, input logic atc);
        checks++;
        if (e.cyc != cyc || aq !== e.q || at !== e.tick || atc !== e.tc) begin
            failures++;
            $display("FAIL %s cyc=%0d exp_cyc=%0d q=%0d exp_q=%0d tick=%0b exp_tick=%0b tc=%0b exp_tc=%0b",
                     nm, cyc, e.cyc, aq, e.q, at, e.tick, atc, e.tc);
        end
    endtask

    always @(negedge clki) begin
        if (tick || tc || (sb.size() > 0 && sb[0].chk && sb[0].cyc == cyc)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL div3_unexpected cyc=%0d q=%0d tick=%0b tc=%0b required=no_pulse",
                         cyc, q, tick, tc);
            end else begin
                compare("div3", sb.pop_front(), q, tick, tc);
            end
        end
    end

    always @(negedge clki) begin
        if (tick1 || tc1 || (sb1.size() > 0 && sb1[0].chk && sb1[0].cyc == cyc)) begin
            if (sb1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL div1_unexpected cyc=%0d q=%0d tick=%0b tc=%0b required=no_pulse",
                         cyc, q1, tick1, tc1);
            end else begin
                compare("div1", sb1.pop_front(), q1, tick1, tc1);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clki);
        #1;
    endtask

    initial begin
        // reset state, both instances
        sb.push_back(mk(2, 4'd0, 1'b0, 1'b0, 1'b1));
        sb1.push_back(mk(2, 4'd0, 1'b0, 1'b0, 1'b1));
        step(2);

        // count up 0..9 then wrap (or saturate), step every 3 cycles
        for (int k = 1; k <= 10; k++) begin
            sb.push_back(mk(2 + 3 * k,
                            (k < 10) ? 4'(k) : (SAT ? 4'd9 : 4'd0),
                            (k < 10) ? 1'b1 : !SAT,
                            k == 10, 1'b0));
        end
        rs = 1'b0;
        step(30);

        // load 0, then count down
        ld = 1'b1; d = 4'd0; up = 1'b0;
        sb.push_back(mk(33, 4'd0, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(36, SAT ? 4'd0 : 4'd9, !SAT, 1'b1, 1'b0));
        sb.push_back(mk(39, SAT ? 4'd0 : 4'd8, !SAT, SAT, 1'b0));
        sb.push_back(mk(42, SAT ? 4'd0 : 4'd7, !SAT, SAT, 1'b0));
        step(1);
        ld = 1'b0;
        step(9);

        // load 7 on the same edge as a strobe: strobe discarded, next step 3 later
        sb.push_back(mk(45, 4'd7, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(48, 4'd8, 1'b1, 1'b0, 1'b0));
        step(2);
        ld = 1'b1; d = 4'd7; up = 1'b1;
        step(1);
        ld = 1'b0;
        step(3);

        // clamped load with en low, then en toggling every cycle
        sb.push_back(mk(49, 4'd9, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(54, 4'd8, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(55, 4'd8, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(59, 4'd8, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(60, 4'd7, 1'b1, 1'b0, 1'b0));
        ld = 1'b1; d = 4'd13; en = 1'b0; up = 1'b0;
        step(1);
        ld = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            en = (i % 2 == 1);
            step(1);
        end

        // reset mid-count at q=5, pcnt=1; next step must come a full 3 cycles after release
        sb.push_back(mk(62, 4'd5, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(64, 4'd0, 1'b0, 1'b0, 1'b1));
        sb.push_back(mk(67, 4'd1, 1'b1, 1'b0, 1'b0));
        ld = 1'b1; d = 4'd5;
        step(1);
        ld = 1'b0; en = 1'b1;
        step(1);
        rs = 1'b1;
        step(1);
        rs = 1'b0; up = 1'b1;
        step(3);
        en = 1'b0;

        // DIV=1: steps on every cycle after release, then reset
        sb1.push_back(mk(68, 4'd1, 1'b1, 1'b0, 1'b0));
        sb1.push_back(mk(69, 4'd2, 1'b1, 1'b0, 1'b0));
        sb1.push_back(mk(70, 4'd3, 1'b1, 1'b0, 1'b0));
        sb1.push_back(mk(71, 4'd0, 1'b0, 1'b0, 1'b1));
        rs1 = 1'b0;
        step(3);
        rs1 = 1'b1;
        step(1);
        step(4);

        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL div3_drain pending=%0d required=0", sb.size());
        end
        checks++;
        if (sb1.size() != 0) begin
            failures++;
            $display("FAIL div1_drain pending=%0d required=0", sb1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
